// File: rtl/core_pkg.sv
// core_pkg: shared front-end widths, fetch-entry type and pointer-width helper
package core_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-packet and decode-lane bundle between front end and fetch queue
interface fetch_queue_if import core_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = core_pkg::XLEN
);
  logic flush_i;
  logic fetch_valid_i;
  logic [FETCH_WIDTH*XLEN-1:0] fetch_data_i;
  logic [FETCH_WIDTH-1:0] fetch_mask_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic fetch_ready_o;
  logic [ISSUE_WIDTH-1:0] dec_valid_o;
  logic [ISSUE_WIDTH*XLEN-1:0] dec_inst_o;
  logic [ISSUE_WIDTH*XLEN-1:0] dec_pc_o;
  logic [$clog2(ISSUE_WIDTH+1)-1:0] dec_take_i;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic empty_o;
  logic full_o;
  modport master (
    output flush_i, fetch_valid_i, fetch_data_i, fetch_mask_i, fetch_pc_i, dec_take_i,
    input fetch_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, count_o, empty_o, full_o
  );
  modport slave (
    input flush_i, fetch_valid_i, fetch_data_i, fetch_mask_i, fetch_pc_i, dec_take_i,
    output fetch_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/fetch_queue_compact.sv
// fetch_compact: packs masked fetch lanes to the low slots with per-lane PCs and a popcount
module fetch_compact import core_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int XLEN = core_pkg::XLEN,
  localparam int FW = $clog2(FETCH_WIDTH+1)
) (
  input  logic [FETCH_WIDTH*XLEN-1:0] data,
  input  logic [FETCH_WIDTH-1:0] mask,
  input  logic [XLEN-1:0] pc,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] inst,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] pcs,
  output logic [FW-1:0] n
);
  always_comb begin
    int c;
    c = 0;
    inst = '0;
    pcs = '0;
    n = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) n = n + FW'(mask[k]);
    // slot s takes the lane whose mask prefix-count equals s; PC keeps the original lane index
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      c = 0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (mask[k] && c == s) begin
          inst[s] = data[k*XLEN +: XLEN];
          pcs[s] = pc + XLEN'(4*k);
        end
        c = c + int'(mask[k]);
      end
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer compacting fetch packets and presenting an in-order head window to decode
module fetch_queue import core_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = core_pkg::XLEN
) (
  input logic clock_i,
  input logic reset_ni,
  fetch_queue_if.slave q
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $clog2(FETCH_WIDTH+1);
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, take, add;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] c_inst, c_pc;
  logic [FW-1:0] n;
  logic ready, enq;
  fetch_compact #(.FETCH_WIDTH(FETCH_WIDTH), .XLEN(XLEN)) u_compact (
    .data(q.fetch_data_i),
    .mask(q.fetch_mask_i),
    .pc(q.fetch_pc_i),
    .inst(c_inst),
    .pcs(c_pc),
    .n(n)
  );
  // ready looks only at the registered count so dec_take_i never reaches fetch_ready_o
  assign ready = count <= CW'(DEPTH - FETCH_WIDTH);
  assign enq = q.fetch_valid_i && ready && !q.flush_i;
  assign add = enq ? CW'(n) : '0;
  assign take = CW'(q.dec_take_i) > count ? count : CW'(q.dec_take_i);
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (q.flush_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(take);
      tail <= tail + PW'(add);
      count <= count + add - take;
    end
  end
  always_ff @(posedge clock_i) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (enq && FW'(k) < n) begin
        mem_inst[tail + PW'(k)] <= c_inst[k];
        mem_pc[tail + PW'(k)] <= c_pc[k];
      end
    end
  end
  always_comb begin
    q.dec_valid_o = '0;
    q.dec_inst_o = '0;
    q.dec_pc_o = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (CW'(j) < count) begin
        q.dec_valid_o[j] = 1'b1;
        q.dec_inst_o[j*XLEN +: XLEN] = mem_inst[head + PW'(j)];
        q.dec_pc_o[j*XLEN +: XLEN] = mem_pc[head + PW'(j)];
      end
    end
  end
  assign q.fetch_ready_o = ready;
  assign q.count_o = count;
  assign q.empty_o = count == '0;
  assign q.full_o = count == CW'(DEPTH);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus reset, flush and full-queue sequences for fetch_queue
module tb_fetch_queue;
  import core_pkg::*;
  typedef struct {
    logic v, fl;
    logic [1:0] mask, take;
    logic [31:0] d1, d0, pc;
    logic [3:0] cnt;
    logic [1:0] val;
    logic [31:0] i0, p0, i1, p1;
    logic rdy;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  vec_t vt [21];
  fetch_queue_if q ();
  fetch_queue u_dut (.clock_i(clk), .reset_ni(rst_n), .q(q));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic fl, logic [1:0] mask, logic [31:0] d1, logic [31:0] d0,
                              logic [31:0] pc, logic [1:0] take, logic [3:0] cnt, logic [1:0] val,
                              logic [31:0] i0, logic [31:0] p0, logic [31:0] i1, logic [31:0] p1, logic rdy);
    vec_t r;
    r.v = v; r.fl = fl; r.mask = mask; r.d1 = d1; r.d0 = d0; r.pc = pc; r.take = take;
    r.cnt = cnt; r.val = val; r.i0 = i0; r.p0 = p0; r.i1 = i1; r.p1 = p1; r.rdy = rdy;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic fl, input logic [1:0] mask, input logic [31:0] d1,
                       input logic [31:0] d0, input logic [31:0] pc, input logic [1:0] take);
    q.fetch_valid_i = v;
    q.flush_i = fl;
    q.fetch_mask_i = mask;
    q.fetch_data_i = {d1, d0};
    q.fetch_pc_i = pc;
    q.dec_take_i = take;
  endtask
  task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [1:0] val,
                           input logic [31:0] i0, input logic [31:0] p0, input logic [31:0] i1,
                           input logic [31:0] p1, input logic rdy);
    chk({tag, ".count"}, 32'(q.count_o), 32'(cnt));
    chk({tag, ".valid"}, 32'(q.dec_valid_o), 32'(val));
    chk({tag, ".inst0"}, q.dec_inst_o[31:0], i0);
    chk({tag, ".pc0"}, q.dec_pc_o[31:0], p0);
    chk({tag, ".inst1"}, q.dec_inst_o[63:32], i1);
    chk({tag, ".pc1"}, q.dec_pc_o[63:32], p1);
    chk({tag, ".ready"}, 32'(q.fetch_ready_o), 32'(rdy));
    chk({tag, ".empty"}, 32'(q.empty_o), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(q.full_o), 32'(cnt == 8));
  endtask
  initial begin
    vt[0]  = mk(1, 0, 2'b11, 32'h00100093, 32'h00000013, 32'h100, 0, 2, 2'b11, 32'h13, 32'h100, 32'h00100093, 32'h104, 1);
    vt[1]  = mk(1, 0, 2'b10, 32'hAAAA0001, 32'hBBBB0000, 32'h200, 0, 3, 2'b11, 32'h13, 32'h100, 32'h00100093, 32'h104, 1);
    vt[2]  = mk(0, 0, 2'b00, 0, 0, 0, 2, 1, 2'b01, 32'hAAAA0001, 32'h204, 0, 0, 1);
    vt[3]  = mk(1, 0, 2'b01, 0, 32'h11, 32'h300, 0, 2, 2'b11, 32'hAAAA0001, 32'h204, 32'h11, 32'h300, 1);
    vt[4]  = mk(1, 0, 2'b11, 32'h22, 32'h21, 32'h400, 0, 4, 2'b11, 32'hAAAA0001, 32'h204, 32'h11, 32'h300, 1);
    vt[5]  = mk(1, 0, 2'b11, 32'h32, 32'h31, 32'h500, 0, 6, 2'b11, 32'hAAAA0001, 32'h204, 32'h11, 32'h300, 1);
    vt[6]  = mk(1, 0, 2'b01, 0, 32'h41, 32'h600, 0, 7, 2'b11, 32'hAAAA0001, 32'h204, 32'h11, 32'h300, 0);
    vt[7]  = mk(1, 0, 2'b11, 32'h52, 32'h51, 32'h700, 0, 7, 2'b11, 32'hAAAA0001, 32'h204, 32'h11, 32'h300, 0);
    vt[8]  = mk(1, 0, 2'b11, 32'h52, 32'h51, 32'h700, 2, 5, 2'b11, 32'h21, 32'h400, 32'h22, 32'h404, 1);
    vt[9]  = mk(0, 0, 2'b00, 0, 0, 0, 2, 3, 2'b11, 32'h31, 32'h500, 32'h32, 32'h504, 1);
    vt[10] = mk(0, 0, 2'b00, 0, 0, 0, 2, 1, 2'b01, 32'h41, 32'h600, 0, 0, 1);
    vt[11] = mk(0, 0, 2'b00, 0, 0, 0, 2, 0, 2'b00, 0, 0, 0, 0, 1);
    vt[12] = mk(1, 0, 2'b11, 32'h62, 32'h61, 32'h800, 0, 2, 2'b11, 32'h61, 32'h800, 32'h62, 32'h804, 1);
    vt[13] = mk(1, 0, 2'b11, 32'h72, 32'h71, 32'h900, 2, 2, 2'b11, 32'h71, 32'h900, 32'h72, 32'h904, 1);
    vt[14] = mk(1, 0, 2'b11, 32'h82, 32'h81, 32'hA00, 2, 2, 2'b11, 32'h81, 32'hA00, 32'h82, 32'hA04, 1);
    vt[15] = mk(0, 0, 2'b00, 0, 0, 0, 2, 0, 2'b00, 0, 0, 0, 0, 1);
    vt[16] = mk(1, 0, 2'b11, 32'h92, 32'h91, 32'hB00, 2, 2, 2'b11, 32'h91, 32'hB00, 32'h92, 32'hB04, 1);
    vt[17] = mk(1, 0, 2'b11, 32'hA2, 32'hA1, 32'hFFFFFFFC, 1, 3, 2'b11, 32'h92, 32'hB04, 32'hA1, 32'hFFFFFFFC, 1);
    vt[18] = mk(1, 1, 2'b11, 32'h5, 32'h5, 32'hC00, 1, 0, 2'b00, 0, 0, 0, 0, 1);
    vt[19] = mk(1, 0, 2'b00, 32'h7, 32'h7, 32'hC80, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    vt[20] = mk(1, 0, 2'b11, 32'hC2, 32'hC1, 32'hD00, 0, 2, 2'b11, 32'hC1, 32'hD00, 32'hC2, 32'hD04, 1);
    drive(1, 0, 2'b11, 32'h1, 32'h2, 32'h40, 0);
    repeat (2) @(posedge clk);
    #1 chk_state("reset", 0, 2'b00, 0, 0, 0, 0, 1);
    rst_n = 1;
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].v, vt[i].fl, vt[i].mask, vt[i].d1, vt[i].d0, vt[i].pc, vt[i].take);
      @(posedge clk);
      #1 chk_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].val, vt[i].i0, vt[i].p0, vt[i].i1, vt[i].p1, vt[i].rdy);
    end
    drive(1, 0, 2'b11, 32'hE2, 32'hE1, 32'hE00, 0);
    rst_n = 0;
    #1 chk_state("midrst", 0, 2'b00, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1 chk_state("rel", 2, 2'b11, 32'hE1, 32'hE00, 32'hE2, 32'hE04, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b11, 32'hF0 + 32'(i), 32'hF0 + 32'(i), 32'hF00 + 32'(i) * 32'h100, 0);
      @(posedge clk);
      #1 chk_state($sformatf("fill%0d", i), 4'(4 + 2*i), 2'b11, 32'hE1, 32'hE00, 32'hE2, 32'hE04, i < 2);
    end
    drive(1, 0, 2'b11, 32'h99, 32'h99, 32'h2000, 2);
    @(posedge clk);
    #1 chk_state("drainfull", 6, 2'b11, 32'hF0, 32'hF00, 32'hF0, 32'hF04, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
